// File: rtl/instr_defs_pkg.sv
// Shared instruction definitions: MIPS opcodes (same values as the control decoder),
// request kind encodings and the loader FSM state type.
package instr_defs;

    localparam logic [5:0] OP_R_TYPE = 6'd0;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_SW     = 6'd43;
    localparam logic [5:0] OP_J      = 6'd2;

    typedef enum logic [2:0] {
        KIND_R   = 3'd0,
        KIND_BEQ = 3'd1,
        KIND_LW  = 3'd2,
        KIND_SW  = 3'd3,
        KIND_J   = 3'd4
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational packer: request kind plus fields -> 32-bit MIPS word and a legality flag.
module instr_pack
    import instr_defs::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        legal,
    output logic [31:0] word
);

    always_comb begin
        legal = 1'b1;
        word  = '0;
        case (kind)
            KIND_R:   word = {OP_R_TYPE, rs, rt, rd, 5'd0, funct};
            KIND_BEQ: word = {OP_BEQ, rs, rt, imm};
            KIND_LW:  word = {OP_LW, rs, rt, imm};
            KIND_SW:  word = {OP_SW, rs, rt, imm};
            KIND_J:   word = {OP_J, target};
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts symbolic instruction requests over valid/ready, encodes them
// and writes one word per two cycles sequentially into instruction memory.
module instr_encoder_loader
    import instr_defs::*;
#(
    parameter int ADDR_W     = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_last,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [5:0]        req_funct,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              err_kind,
    output logic [ADDR_W:0]   instr_count,
    output state_e            dbg_state
);

    localparam int                LAST_I     = MEM_DEPTH - 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = LAST_I[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] FIRST_ADDR = START_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   MAX_COUNT  = MEM_DEPTH[ADDR_W:0];

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready depends only on the FSM state, never on req_valid.

    state_e              state_q, state_d;
    logic [31:0]         word_q, word_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;
    logic                pack_legal;
    logic [31:0]         pack_word;

    instr_pack u_pack (
        .kind   (req_kind),
        .rs     (req_rs),
        .rt     (req_rt),
        .rd     (req_rd),
        .funct  (req_funct),
        .imm    (req_imm),
        .target (req_target),
        .legal  (pack_legal),
        .word   (pack_word)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        addr_d  = addr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    state_d = ST_ACCEPT;
                    addr_d  = FIRST_ADDR;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_ACCEPT: begin
                if (req_valid) begin
                    if (pack_legal) begin
                        word_d  = pack_word;
                        last_d  = req_last;
                        state_d = ST_WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (count_q != MAX_COUNT) count_d = count_q + 1'b1;
                // The final memory word ends the session; address is held so it never wraps.
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                    ovf_d   = ~last_q;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = last_q ? ST_DONE : ST_ACCEPT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            last_q  <= 1'b0;
            addr_q  <= FIRST_ADDR;
            count_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign req_ready   = (state_q == ST_ACCEPT);
    assign imem_we     = (state_q == ST_WRITE);
    assign imem_addr   = addr_q;
    assign imem_wdata  = word_q;
    assign busy        = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    assign done        = (state_q == ST_DONE);
    assign overflow    = ovf_q;
    assign err_kind    = err_q;
    assign instr_count = count_q;
    assign dbg_state   = state_q;

endmodule
